// File: rtl/cuenta_unos_param.sv
// -----------------------------------------------------------------------------
// cuenta_unos_param
//   Sequential population counter. It counts the ones (modo=0) or the zeros
//   (modo=1) of an N-bit word, one bit per clock. The operand shifts right
//   each cycle, and the count stops as soon as the remaining word is zero, so
//   no cycles are spent on leading zeros.
//
// Parameters
//   N        operand width in bits, 2..32
//   CW       count width, ceil(log2(N+1)), so that a count of N fits
//
// Ports
//   i_clk      clock; all state changes on its rising edge
//   i_reset    asynchronous reset, active low
//   i_start    starts a new count (accepted in REPOSO or FIN only)
//   i_modo     0: count ones, 1: count zeros (sampled together with i_start)
//   i_valor    operand word (sampled together with i_start)
//   o_cuenta   registered count result
//   o_fin      registered done flag, held until the next accepted start
//   o_ocupado  high while a count is in progress (state CUENTA)
// -----------------------------------------------------------------------------
module cuenta_unos_param #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_modo,
    input  logic [N-1:0]  i_valor,
    output logic [CW-1:0] o_cuenta,
    output logic          o_fin,
    output logic          o_ocupado
);

    typedef enum logic [1:0] {
        REPOSO = 2'd0,
        CUENTA = 2'd1,
        FIN    = 2'd2
    } estado_t;

    estado_t       r_estado, w_estado_sig;
    logic [N-1:0]  r_reg,    w_reg_sig;
    logic [CW-1:0] r_cuenta, w_cuenta_sig;
    logic          r_fin,    w_fin_sig;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_estado <= REPOSO;
            r_reg    <= '0;
            r_cuenta <= '0;
            r_fin    <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_reg    <= w_reg_sig;
            r_cuenta <= w_cuenta_sig;
            r_fin    <= w_fin_sig;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        w_reg_sig    = r_reg;
        w_cuenta_sig = r_cuenta;
        w_fin_sig    = r_fin;
        case (r_estado)
            REPOSO, FIN: begin
                // Counting zeros is counting the ones of the inverted word.
                if (i_start) begin
                    w_reg_sig    = i_modo ? ~i_valor : i_valor;
                    w_cuenta_sig = '0;
                    w_fin_sig    = 1'b0;
                    w_estado_sig = CUENTA;
                end
            end
            CUENTA: begin
                // Once the remaining word is zero there is nothing left to
                // count, so finish immediately. i_start is ignored here.
                if (r_reg != '0) begin
                    w_cuenta_sig = r_cuenta + CW'(r_reg[0]);
                    w_reg_sig    = r_reg >> 1;
                end else begin
                    w_fin_sig    = 1'b1;
                    w_estado_sig = FIN;
                end
            end
            default: begin
                w_estado_sig = REPOSO;
            end
        endcase
    end

    assign o_cuenta  = r_cuenta;
    assign o_fin     = r_fin;
    assign o_ocupado = (r_estado == CUENTA);

endmodule

// File: tb/tb_cuenta_unos_param.sv
module tb_cuenta_unos_param;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          modo = 1'b0;
    logic [N-1:0]  valor = '0;
    logic [CW-1:0] cuenta;
    logic          fin;
    logic          ocupado;

    int tests = 0;
    int fails = 0;

    cuenta_unos_param #(.N(N)) dut (
        .i_clk     (clk),
        .i_reset   (rst_n),
        .i_start   (start),
        .i_modo    (modo),
        .i_valor   (valor),
        .o_cuenta  (cuenta),
        .o_fin     (fin),
        .o_ocupado (ocupado)
    );

    always #5 clk = ~clk;

    // Latency is counted with the edge that samples start as edge 1.
    typedef struct {
        logic          m;
        logic [N-1:0]  v;
        logic [CW-1:0] cnt;
        int            lat;
    } vec_t;

    typedef struct {
        logic [CW-1:0] cnt;
        int            lat;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Reference model: popcount of the effective word, and p+2 latency.
    function automatic exp_t model(input logic m, input logic [N-1:0] v);
        exp_t e;
        logic [N-1:0] r;
        int p;
        r = m ? ~v : v;
        e.cnt = '0;
        p = 0;
        for (int i = 0; i < N; i++) begin
            if (r[i]) begin
                e.cnt = e.cnt + 1'b1;
                p = i + 1;
            end
        end
        e.lat = p + 2;
        return e;
    endfunction

    // One full operation. If inject is set, a spurious start with different
    // operands is driven on the third edge of the count.
    task automatic run_op(input logic m, input logic [N-1:0] v, input bit inject);
        exp_t e;
        exp_t got;
        int n;
        @(negedge clk);
        start = 1'b1;
        modo  = m;
        valor = v;
        sb.push_back(model(m, v));
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check("load_fin_low", fin, 0);
        check("load_cuenta_clear", cuenta, 0);
        check("load_ocupado", ocupado, 1);
        while (!fin && n < N + 6) begin
            if (inject && n == 3) begin
                start = 1'b1;
                modo  = ~m;
                valor = ~v ^ 8'h5A;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        got.cnt = cuenta;
        got.lat = n;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = sb.pop_front();
            check("fin_seen", fin, 1);
            check("cuenta", got.cnt, e.cnt);
            check("latency", got.lat, e.lat);
            check("ocupado_at_fin", ocupado, 0);
            repeat (3) @(posedge clk);
            #1;
            check("hold_fin", fin, 1);
            check("hold_cuenta", cuenta, e.cnt);
        end
    endtask

    // Invariants checked every cycle.
    logic [CW-1:0] pre_cuenta;
    logic          pre_busy, pre_start, pre_rst;
    always @(posedge clk) begin
        pre_cuenta = cuenta;
        pre_busy   = ocupado;
        pre_start  = start;
        pre_rst    = rst_n;
    end
    always @(negedge clk) begin
        if (rst_n && pre_rst) begin
            tests++;
            if (fin && ocupado) begin
                fails++;
                $display("FAIL inv_fin_ocupado: fin=%0d ocupado=%0d, required not both", fin, ocupado);
            end
            if (int'(cuenta) > N) begin
                fails++;
                $display("FAIL inv_cuenta_max: cuenta=%0d, required <= %0d", cuenta, N);
            end
            if (cuenta != pre_cuenta && !(pre_busy || pre_start)) begin
                fails++;
                $display("FAIL inv_cuenta_change: %0d -> %0d outside count/start", pre_cuenta, cuenta);
            end
        end
    end

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b0, 8'hB2, 4'd4, 10};
        tbl[1] = '{1'b0, 8'h00, 4'd0, 2};
        tbl[2] = '{1'b0, 8'hFF, 4'd8, 10};
        tbl[3] = '{1'b1, 8'hFE, 4'd1, 3};
        tbl[4] = '{1'b1, 8'hFF, 4'd0, 2};
        tbl[5] = '{1'b0, 8'h0F, 4'd4, 6};
        tbl[6] = '{1'b1, 8'h00, 4'd8, 10};
        tbl[7] = '{1'b0, 8'h01, 4'd1, 3};
        tbl[8] = '{1'b0, 8'h80, 4'd1, 10};

        // Reset state.
        #12;
        check("rst_cuenta", cuenta, 0);
        check("rst_fin", fin, 0);
        check("rst_ocupado", ocupado, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: hand-derived expectations, cross-checked against the model,
        // then run through the scoreboard (consecutive runs start from FIN).
        foreach (tbl[i]) begin
            exp_t e;
            e = model(tbl[i].m, tbl[i].v);
            check("tbl_model_cnt", e.cnt, tbl[i].cnt);
            check("tbl_model_lat", e.lat, tbl[i].lat);
            run_op(tbl[i].m, tbl[i].v, 1'b0);
        end

        // Start plus changed operands injected mid-count.
        run_op(1'b0, 8'hB2, 1'b1);
        run_op(1'b1, 8'h3C, 1'b1);

        // Random operands.
        for (int k = 0; k < 12; k++)
            run_op(1'(($urandom) & 1), N'($urandom), 1'b0);

        // Asynchronous reset in the middle of a count.
        @(negedge clk);
        start = 1'b1;
        modo  = 1'b0;
        valor = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("pre_rst_ocupado", ocupado, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_cuenta", cuenta, 0);
        check("async_rst_fin", fin, 0);
        check("async_rst_ocupado", ocupado, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_held_ocupado", ocupado, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle", ocupado, 0);
        run_op(1'b0, 8'h0F, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cuenta_unos_param.md
CUENTA_UNOS_PARAM -- requirements
Module: cuenta_unos_param

Interface
REQ-001 Parameter N, default 8, SHALL set the input word width in bits (legal range 2..32).
REQ-002 Derived width CW = ceil(log2(N+1)) SHALL size the count output, so that a count of N is representable.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 start  input  1  SHALL request a new count; it is sampled on the rising edge of clk.
REQ-006 modo  input  1  SHALL select the counting mode: 0 counts ones, 1 counts zeros; it is sampled together with start.
REQ-007 valor  input  N  SHALL be the operand word; it is sampled together with start.
REQ-008 cuenta  output  CW  SHALL be the registered count result.
REQ-009 fin  output  1  SHALL be the registered done flag.
REQ-010 ocupado  output  1  SHALL be high while the FSM is in CUENTA.

Function
REQ-011 FSM states SHALL be REPOSO, CUENTA and FIN; the encoding is free.
REQ-012 In REPOSO or FIN, start=1 SHALL load the internal register R with valor (modo=0) or ~valor (modo=1), clear cuenta, clear fin, and go to CUENTA.
REQ-013 In REPOSO or FIN, while start=0, the FSM SHALL stay in its current state with all outputs held.
REQ-014 In CUENTA, if R!=0 at an edge, the block SHALL perform cuenta <= cuenta + R[0] and R <= R >> 1 (logical shift), and SHALL stay in CUENTA.
REQ-015 In CUENTA, if R==0 at an edge, the block SHALL set fin <= 1, hold cuenta, and go to FIN. This early termination applies whenever R becomes 0, so no cycles are spent on leading zeros.
REQ-016 Latency: let p = (index of the highest set bit of R at load) + 1, with p=0 if R==0. fin SHALL go high p+2 rising edges after the edge that sampled start. The maximum latency is N+2.
REQ-017 start SHALL be ignored while in CUENTA; valor and modo SHALL NOT affect an operation in progress.
REQ-018 In FIN, fin=1 and cuenta SHALL remain stable until the next accepted start. On that start's edge, fin SHALL drop and cuenta SHALL clear.
REQ-019 cuenta SHALL never exceed N; no wrap-around is possible by construction.
REQ-020 ocupado SHALL be 1 exactly in CUENTA and 0 in REPOSO and FIN.
REQ-021 fin and ocupado SHALL never be high at the same time.

Reset
REQ-022 reset=0 SHALL immediately, independent of clk, force state=REPOSO, R=0, cuenta=0, fin=0 and ocupado=0.
REQ-023 reset asserted mid-operation SHALL abort the count with no result retained.
REQ-024 After reset deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (N=8)
REQ-025 valor=8'b1011_0010, modo=0, 1-cycle start -> ocupado high; fin=1 with cuenta=4 at the 10th edge after start; both held until the next start.
REQ-026 valor=8'h00, modo=0 -> fin=1 and cuenta=0 at the 2nd edge after start; valor=8'hFF, modo=0 -> cuenta=8 (4'b1000) at the 10th edge.
REQ-027 valor=8'hFE, modo=1 -> R=8'h01, cuenta=1 at the 3rd edge (early termination); valor=8'hFF, modo=1 -> cuenta=0 at the 2nd edge.
REQ-028 Start pulse plus changed valor/modo injected during CUENTA -> no effect on result or timing; start in FIN -> fin drops and cuenta=0 on the next edge, then the new result.
REQ-029 reset pulled low mid-count, between edges -> cuenta, fin and ocupado go to 0 before the next clk edge; after release a fresh count of 8'h0F gives cuenta=4 at the 6th edge.
REQ-030 All runs -> assertion checks: fin and ocupado never both high; cuenta <= N; cuenta changes only in CUENTA or on an accepted start.
